rename_reg_file: RTL and testbench

//  Architectural register file with per-register rename tags for the Tomasulo core.

---
 rtl/rename_reg_file_pkg.sv | 18 +
 rtl/rename_reg_file_rf_read_port.sv | 45 ++++
 rtl/rename_reg_file.sv | 117 +++++++++++
 tb/tb_rename_reg_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rename_reg_file_pkg.sv
// Shared constants and types for the renaming register file.
// Reset values and per-register update kinds.
package rename_reg_file_pkg;

   localparam logic TRUE       = 1'b1;
   localparam logic FALSE      = 1'b0;
   localparam int   REG_RESET  = 0;
   localparam int   DATA_RESET = 0;
   localparam int   ROB_RESET  = 0;

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_FLUSH,
      UPD_DISP,
      UPD_CLR
   } upd_e;

endpackage

// File: rtl/rename_reg_file_rf_read_port.sv
// One operand read port: index mux, x0 masking and,
// with RENAME_RF_BYPASS_EN, commit-to-read forwarding.
module rf_read_port
   import rename_reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32,
   parameter int TAG_W    = 4,
   parameter int IDX_W    = 5
) (
   input  logic [IDX_W-1:0]          rd_idx,
   input  logic [NUM_REGS*XLEN-1:0]  reg_data,
   input  logic [NUM_REGS-1:0]       reg_busy,
   input  logic [NUM_REGS*TAG_W-1:0] reg_tag,
`ifdef RENAME_RF_BYPASS_EN
   input  logic                      cmt_en,
   input  logic [IDX_W-1:0]          cmt_rd,
   input  logic [TAG_W-1:0]          cmt_tag,
   input  logic [XLEN-1:0]           cmt_val,
`endif
   output logic [XLEN-1:0]           rd_val,
   output logic                      rd_busy,
   output logic [TAG_W-1:0]          rd_tag
);

   // Select the addressed register; x0 and out-of-range read as zero.
   always_comb begin
      rd_val  = XLEN'(DATA_RESET);
      rd_busy = FALSE;
      rd_tag  = TAG_W'(ROB_RESET);
      if (rd_idx != '0 && int'(rd_idx) < NUM_REGS) begin
         rd_val  = reg_data[int'(rd_idx)*XLEN +: XLEN];
         rd_busy = reg_busy[rd_idx];
         rd_tag  = reg_tag[int'(rd_idx)*TAG_W +: TAG_W];
`ifdef RENAME_RF_BYPASS_EN
         if (cmt_en && cmt_rd == rd_idx) begin
            rd_val = cmt_val;
            if (rd_busy && rd_tag == cmt_tag)
               rd_busy = FALSE;
         end
`endif
      end
   end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags.
// Optional commit bypass on reads: define RENAME_RF_BYPASS_EN.
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32,
   parameter int TAG_W    = 4,
   parameter int NUM_RD   = 2,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    disp_en,
   input  logic [IDX_W-1:0]        disp_rd,
   input  logic [TAG_W-1:0]        disp_tag,
   input  logic                    cmt_en,
   input  logic [IDX_W-1:0]        cmt_rd,
   input  logic [TAG_W-1:0]        cmt_tag,
   input  logic [XLEN-1:0]         cmt_val,
   input  logic                    flush_en,
   input  logic [NUM_RD*IDX_W-1:0] rs_idx,
   output logic [NUM_RD*XLEN-1:0]  rs_val,
   output logic [NUM_RD-1:0]       rs_busy,
   output logic [NUM_RD*TAG_W-1:0] rs_tag
);

   logic [XLEN-1:0]  data_q [NUM_REGS];
   logic             busy_q [NUM_REGS];
   logic [TAG_W-1:0] tag_q  [NUM_REGS];

   upd_e             upd    [NUM_REGS];
   logic             wr_hit [NUM_REGS];

   logic [NUM_REGS*XLEN-1:0]  data_flat;
   logic [NUM_REGS-1:0]       busy_flat;
   logic [NUM_REGS*TAG_W-1:0] tag_flat;

   // Per-register update decision: flush > dispatch > commit-clear.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         upd[i]    = UPD_NONE;
         wr_hit[i] = FALSE;
         if (i != 0) begin
            wr_hit[i] = cmt_en && cmt_rd == IDX_W'(i);
            if (flush_en)
               upd[i] = UPD_FLUSH;
            else if (disp_en && disp_rd == IDX_W'(i))
               upd[i] = UPD_DISP;
            else if (wr_hit[i] && busy_q[i] && tag_q[i] == cmt_tag)
               upd[i] = UPD_CLR;
         end
      end
   end

   // State update; x0 keeps its reset value forever.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            data_q[i] <= XLEN'(DATA_RESET);
            busy_q[i] <= 1'(REG_RESET);
            tag_q[i]  <= TAG_W'(ROB_RESET);
         end
      end else if (rdy_in) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_hit[i])
               data_q[i] <= cmt_val;
            unique case (upd[i])
               UPD_FLUSH: busy_q[i] <= FALSE;
               UPD_DISP: begin
                  busy_q[i] <= TRUE;
                  tag_q[i]  <= disp_tag;
               end
               UPD_CLR:  busy_q[i] <= FALSE;
               default:  ;
            endcase
         end
      end
   end

   // Flatten the arrays for the read ports.
   always_comb begin
      data_flat = '0;
      busy_flat = '0;
      tag_flat  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         data_flat[i*XLEN +: XLEN]   = data_q[i];
         busy_flat[i]                = busy_q[i];
         tag_flat[i*TAG_W +: TAG_W]  = tag_q[i];
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      rf_read_port #(
         .NUM_REGS (NUM_REGS),
         .XLEN     (XLEN),
         .TAG_W    (TAG_W),
         .IDX_W    (IDX_W)
      ) u_port (
         .rd_idx   (rs_idx[k*IDX_W +: IDX_W]),
         .reg_data (data_flat),
         .reg_busy (busy_flat),
         .reg_tag  (tag_flat),
`ifdef RENAME_RF_BYPASS_EN
         .cmt_en   (cmt_en),
         .cmt_rd   (cmt_rd),
         .cmt_tag  (cmt_tag),
         .cmt_val  (cmt_val),
`endif
         .rd_val   (rs_val[k*XLEN +: XLEN]),
         .rd_busy  (rs_busy[k]),
         .rd_tag   (rs_tag[k*TAG_W +: TAG_W])
      );
   end

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file.
// Expected reads are queued with the stimulus and drained after the edge.
module tb_rename_reg_file;

   localparam int NR = 2;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        disp_en, cmt_en, flush_en;
   logic [4:0]  disp_rd, cmt_rd;
   logic [3:0]  disp_tag, cmt_tag;
   logic [31:0] cmt_val;
   logic [9:0]  rs_idx;
   logic [63:0] rs_val;
   logic [1:0]  rs_busy;
   logic [7:0]  rs_tag;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       nm;
      logic [4:0]  idx;
      logic [31:0] v;
      logic        b;
      logic [3:0]  t;
      logic        ct;
   } exp_t;

   exp_t sb[$];

   always #5 clk_in = ~clk_in;

   rename_reg_file dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .disp_en  (disp_en),
      .disp_rd  (disp_rd),
      .disp_tag (disp_tag),
      .cmt_en   (cmt_en),
      .cmt_rd   (cmt_rd),
      .cmt_tag  (cmt_tag),
      .cmt_val  (cmt_val),
      .flush_en (flush_en),
      .rs_idx   (rs_idx),
      .rs_val   (rs_val),
      .rs_busy  (rs_busy),
      .rs_tag   (rs_tag)
   );

   task automatic chk(input string tg, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tg, got, exp);
      end
   endtask

   task automatic push(input string nm, input int idx,
                       input logic [31:0] v, input logic b,
                       input logic [3:0] t, input logic ct);
      exp_t e;
      e.nm = nm; e.idx = 5'(idx); e.v = v;
      e.b = b; e.t = t; e.ct = ct;
      sb.push_back(e);
   endtask

   // Pop every queued expectation and compare on both read ports.
   task automatic drain(input bit at_edge);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (at_edge) @(negedge clk_in);
         rs_idx = {e.idx, e.idx};
         #1;
         for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s_p%0d_val", e.nm, k),
                rs_val[k*32 +: 32], e.v);
            chk($sformatf("%s_p%0d_busy", e.nm, k),
                32'(rs_busy[k]), 32'(e.b));
            if (e.ct)
               chk($sformatf("%s_p%0d_tag", e.nm, k),
                   32'(rs_tag[k*4 +: 4]), 32'(e.t));
         end
      end
   endtask

   task automatic idle();
      disp_en = 0; disp_rd = 0; disp_tag = 0;
      cmt_en = 0; cmt_rd = 0; cmt_tag = 0; cmt_val = 0;
      flush_en = 0; rdy_in = 1;
   endtask

   // Drive one cycle of stimulus, sampled by the next rising edge.
   task automatic step(input logic de, input int dr, input int dt,
                       input logic ce, input int cr, input int ct,
                       input logic [31:0] cv, input logic fl,
                       input logic rdy);
      @(negedge clk_in);
      disp_en = de; disp_rd = 5'(dr); disp_tag = 4'(dt);
      cmt_en = ce; cmt_rd = 5'(cr); cmt_tag = 4'(ct);
      cmt_val = cv; flush_en = fl; rdy_in = rdy;
      @(posedge clk_in);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rs_idx = '0;
      rst_in = 1;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 0;

      push("rst_r5", 5, 32'h0, 1'b0, 4'h0, 1'b1);
      push("rst_r0", 0, 32'h0, 1'b0, 4'h0, 1'b1);
      drain(1);

      step(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 1);
      push("t1_r5", 5, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0);
      drain(1);

      step(1, 7, 2, 0, 0, 0, 32'h0, 0, 1);
      step(0, 0, 0, 1, 7, 1, 32'h11, 0, 1);
      push("t2a_r7", 7, 32'h11, 1'b1, 4'h2, 1'b1);
      drain(1);
      step(0, 0, 0, 1, 7, 2, 32'h22, 0, 1);
      push("t2b_r7", 7, 32'h22, 1'b0, 4'h0, 1'b0);
      drain(1);

      step(1, 9, 4, 0, 0, 0, 32'h0, 0, 1);
      step(1, 9, 6, 1, 9, 4, 32'h99, 0, 1);
      push("t3_r9", 9, 32'h99, 1'b1, 4'h6, 1'b1);
      drain(1);

      for (int r = 1; r <= 8; r++)
         step(1, r, r, 0, 0, 0, 32'h0, 0, 1);
      push("t4pre_r4", 4, 32'h0, 1'b1, 4'h4, 1'b1);
      drain(1);
      step(1, 10, 9, 1, 2, 2, 32'h2, 1, 1);
      for (int r = 1; r <= 10; r++) begin
         logic [31:0] v;
         v = 32'h0;
         if (r == 2) v = 32'h2;
         if (r == 5) v = 32'hDEADBEEF;
         if (r == 7) v = 32'h22;
         if (r == 9) v = 32'h99;
         push($sformatf("t4_r%0d", r), r, v, 1'b0, 4'h0, 1'b0);
      end
      drain(1);

      step(1, 0, 1, 1, 0, 1, 32'h55, 0, 1);
      push("t5_r0", 0, 32'h0, 1'b0, 4'h0, 1'b1);
      drain(1);

      step(1, 3, 5, 0, 0, 0, 32'h0, 0, 1);
      @(negedge clk_in);
      cmt_en = 1; cmt_rd = 5'd3; cmt_tag = 4'd5; cmt_val = 32'h77;
`ifdef RENAME_RF_BYPASS_EN
      push("t6_byp", 3, 32'h77, 1'b0, 4'h0, 1'b0);
`else
      push("t6_nobyp", 3, 32'h0, 1'b1, 4'h5, 1'b1);
`endif
      drain(0);
      @(posedge clk_in);
      #1;
      idle();
      push("t6_after", 3, 32'h77, 1'b0, 4'h0, 1'b0);
      drain(1);

      step(1, 7, 3, 0, 0, 0, 32'h0, 0, 0);
      step(0, 0, 0, 1, 7, 3, 32'h33, 0, 0);
      push("rdy0_r7", 7, 32'h22, 1'b0, 4'h0, 1'b0);
      step(1, 12, 2, 0, 0, 0, 32'h0, 1, 0);
      push("rdy0_r12", 12, 32'h0, 1'b0, 4'h0, 1'b0);
      drain(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
